multichannel_coincidence_trigger: RTL and testbench

N-channel coincidence trigger for the neutron detector front end; generalises the two-channel AND/OR edge trigger to a programmable M-of-N majority. Each channel opens a coincidence window on a rising edge of its discriminator input. A one-cycle trigger pulse fires when at least MAJORITY enabled channels are open at once, followed by a programmable holdoff and a re-arm phase. Sits between the discriminator inputs and the readout/ESP32 interface, and reports the firing channel pattern and a trigger count.

---
 rtl/multichannel_coincidence_trigger.sv | 187 ++++++++++++++++++
 tb/tb_multichannel_coincidence_trigger.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multichannel_coincidence_trigger.sv
// multichannel_coincidence_trigger: M-of-N majority coincidence trigger over per-channel
// edge-opened windows, with holdoff and re-arm phases, pattern capture and saturating count.
// Latency: pulse is high in the 2nd cycle after the edge that samples the completing rise
//          (+2 cycles when SIGNAL_SYNC_EN is defined). No flow control; read_mode only inhibits
//          new triggers from IDLE.
// Ports:
//   CLK, RESET (async, active-low)  clock and reset
//   SIGNAL[N_CH]                    discriminator inputs
//   CH_ENABLE, WINDOW, MAJORITY,    run-time configuration, registered every cycle
//   HOLDOFF
//   read_mode                       1 = readout busy, no new trigger is started
//   COUNT_CLR                       synchronous clear of TRIGGER_COUNT (wins over increment)
//   TRIGGER_OUT                     one-cycle registered trigger pulse
//   TRIGGER_PATTERN                 enabled open-window mask captured at trigger
//   TRIGGER_COUNT                   saturating trigger count
//   BUSY                            high in FIRE, HOLDOFF and REARM
// Build option: define SIGNAL_SYNC_EN to insert a 2-flop synchroniser on every SIGNAL bit.
module multichannel_coincidence_trigger #(
   parameter int N_CH      = 4,
   parameter int WIN_W     = 8,
   parameter int HOLDOFF_W = 8,
   parameter int CNT_W     = 16,
   parameter int MAJ_W     = $clog2(N_CH + 1)
) (
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic [N_CH-1:0]      SIGNAL,
   input  logic [N_CH-1:0]      CH_ENABLE,
   input  logic [WIN_W-1:0]     WINDOW,
   input  logic [MAJ_W-1:0]     MAJORITY,
   input  logic [HOLDOFF_W-1:0] HOLDOFF,
   input  logic                 read_mode,
   input  logic                 COUNT_CLR,
   output logic                 TRIGGER_OUT,
   output logic [N_CH-1:0]      TRIGGER_PATTERN,
   output logic [CNT_W-1:0]     TRIGGER_COUNT,
   output logic                 BUSY
);

   typedef enum logic [1:0] {S_IDLE, S_FIRE, S_HOLDOFF, S_REARM} state_t;

   state_t               r_state;
   logic [N_CH-1:0]      r_ch_enable;
   logic [WIN_W-1:0]     r_window;
   logic [MAJ_W-1:0]     r_majority;
   logic [HOLDOFF_W-1:0] r_holdoff;
   logic [N_CH-1:0]      r_signal_d;
   logic [WIN_W-1:0]     r_cdown [N_CH];
   logic [HOLDOFF_W-1:0] r_hold_cnt;
   logic                 r_trigger_out;
   logic                 r_busy;
   logic [N_CH-1:0]      r_pattern;
   logic [CNT_W-1:0]     r_count;

   logic [N_CH-1:0]      w_sig;
   logic [N_CH-1:0]      w_rise;
   logic [N_CH-1:0]      w_open;
   logic [N_CH-1:0]      w_hit_mask;
   logic [MAJ_W-1:0]     w_hits;
   logic                 w_coinc;

`ifdef SIGNAL_SYNC_EN
   logic [N_CH-1:0] r_sync1;
   logic [N_CH-1:0] r_sync2;

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= SIGNAL;
         r_sync2 <= r_sync1;
      end
   end

   assign w_sig = r_sync2;
`else
   assign w_sig = SIGNAL;
`endif

   // Configuration and previous input level; a config change is seen one cycle later.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_ch_enable <= '0;
         r_window    <= '0;
         r_majority  <= '0;
         r_holdoff   <= '0;
         r_signal_d  <= '0;
      end else begin
         r_ch_enable <= CH_ENABLE;
         r_window    <= WINDOW;
         r_majority  <= MAJORITY;
         r_holdoff   <= HOLDOFF;
         r_signal_d  <= w_sig;
      end
   end

   // Only a 0->1 transition opens a window; a held-high level does not.
   assign w_rise = w_sig & ~r_signal_d;

   // Per-channel window countdowns run in every FSM state. A new rise reloads even
   // in the cycle the old window would have expired.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         for (int i = 0; i < N_CH; i++) r_cdown[i] <= '0;
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            if (w_rise[i])
               r_cdown[i] <= r_window;
            else if (r_cdown[i] != '0)
               r_cdown[i] <= r_cdown[i] - WIN_W'(1);
         end
      end
   end

   always_comb begin
      w_open = '0;
      for (int i = 0; i < N_CH; i++) w_open[i] = (r_cdown[i] != '0);
   end

   assign w_hit_mask = w_open & r_ch_enable;

   // hits never exceeds N_CH, so MAJORITY above N_CH can never be met.
   always_comb begin
      w_hits = '0;
      for (int i = 0; i < N_CH; i++)
         if (w_hit_mask[i]) w_hits = w_hits + MAJ_W'(1);
   end

   assign w_coinc = (r_majority != '0) && (w_hits >= r_majority);

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_state       <= S_IDLE;
         r_trigger_out <= 1'b0;
         r_busy        <= 1'b0;
         r_pattern     <= '0;
         r_hold_cnt    <= '0;
         r_count       <= '0;
      end else begin
         r_trigger_out <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_coinc && !read_mode) begin
                  r_state       <= S_FIRE;
                  r_trigger_out <= 1'b1;
                  r_busy        <= 1'b1;
                  r_pattern     <= w_hit_mask;
               end
            end
            S_FIRE: begin
               r_hold_cnt <= r_holdoff;
               r_state    <= (r_holdoff != '0) ? S_HOLDOFF : S_REARM;
            end
            S_HOLDOFF: begin
               // Leaving on count 1 gives exactly HOLDOFF cycles in this state.
               if (r_hold_cnt == HOLDOFF_W'(1))
                  r_state <= S_REARM;
               else
                  r_hold_cnt <= r_hold_cnt - HOLDOFF_W'(1);
            end
            S_REARM: begin
               if (!w_coinc) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase

         // Clear has priority over the FIRE increment.
         if (COUNT_CLR)
            r_count <= '0;
         else if (r_state == S_FIRE && r_count != '1)
            r_count <= r_count + CNT_W'(1);
      end
   end

   assign TRIGGER_OUT     = r_trigger_out;
   assign TRIGGER_PATTERN = r_pattern;
   assign TRIGGER_COUNT   = r_count;
   assign BUSY            = r_busy;

endmodule

// File: tb/tb_multichannel_coincidence_trigger.sv
module tb_multichannel_coincidence_trigger;

   localparam int N_CH      = 4;
   localparam int WIN_W     = 8;
   localparam int HOLDOFF_W = 8;
   localparam int CNT_W     = 4;
   localparam int MAJ_W     = $clog2(N_CH + 1);
   localparam int CMAX      = (1 << CNT_W) - 1;
   localparam int P_IDLE    = 0;
   localparam int P_ACTIVE  = 1;
   localparam int P_REARM   = 2;

   logic                 CLK = 1'b0;
   logic                 RESET = 1'b0;
   logic [N_CH-1:0]      SIGNAL = '0;
   logic [N_CH-1:0]      CH_ENABLE = '0;
   logic [WIN_W-1:0]     WINDOW = '0;
   logic [MAJ_W-1:0]     MAJORITY = '0;
   logic [HOLDOFF_W-1:0] HOLDOFF = '0;
   logic                 read_mode = 1'b0;
   logic                 COUNT_CLR = 1'b0;
   logic                 TRIGGER_OUT;
   logic [N_CH-1:0]      TRIGGER_PATTERN;
   logic [CNT_W-1:0]     TRIGGER_COUNT;
   logic                 BUSY;

   always #5 CLK = ~CLK;

   multichannel_coincidence_trigger #(
      .N_CH(N_CH), .WIN_W(WIN_W), .HOLDOFF_W(HOLDOFF_W), .CNT_W(CNT_W), .MAJ_W(MAJ_W)
   ) dut (
      .CLK(CLK), .RESET(RESET), .SIGNAL(SIGNAL), .CH_ENABLE(CH_ENABLE),
      .WINDOW(WINDOW), .MAJORITY(MAJORITY), .HOLDOFF(HOLDOFF),
      .read_mode(read_mode), .COUNT_CLR(COUNT_CLR),
      .TRIGGER_OUT(TRIGGER_OUT), .TRIGGER_PATTERN(TRIGGER_PATTERN),
      .TRIGGER_COUNT(TRIGGER_COUNT), .BUSY(BUSY)
   );

   int checks = 0;
   int errors = 0;
   int n_pulse = 0;
   int n_busy = 0;

   // Reference model: each channel remembers the edge index of its last rise and the
   // window in force then; it is open while fewer than that many edges have passed.
   // The trigger sequence is tracked with edge timestamps rather than counters.
   int              edge_n = 0;
   int              last_rise [N_CH];
   int              win_at [N_CH];
   int              m_win, m_maj, m_hold;
   int              phase, fire_edge, rearm_edge, m_count;
   logic [N_CH-1:0] m_en, m_sig_prev, m_pipe1, m_pipe2, m_pattern;
   logic            exp_pulse;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N_CH; i++) begin
         last_rise[i] = 0;
         win_at[i]    = 0;
      end
      m_win = 0; m_maj = 0; m_hold = 0;
      phase = P_IDLE; fire_edge = -10; rearm_edge = -10; m_count = 0;
      m_en = '0; m_sig_prev = '0; m_pipe1 = '0; m_pipe2 = '0; m_pattern = '0;
      exp_pulse = 1'b0;
   endtask

   function automatic logic [N_CH-1:0] open_now();
      logic [N_CH-1:0] o;
      o = '0;
      for (int i = 0; i < N_CH; i++) o[i] = ((edge_n - last_rise[i]) < win_at[i]);
      return o;
   endfunction

   task automatic model_edge();
      int              j;
      logic [N_CH-1:0] op;
      logic [N_CH-1:0] s;
      bit              coinc;
      j     = edge_n + 1;
      op    = open_now();
      coinc = (m_maj != 0) && ($countones(op & m_en) >= m_maj);
      exp_pulse = 1'b0;

      if (COUNT_CLR) m_count = 0;
      else if (phase == P_ACTIVE && j == fire_edge + 1 && m_count < CMAX) m_count++;

      case (phase)
         P_IDLE: if (coinc && !read_mode) begin
            phase = P_ACTIVE; fire_edge = j; m_pattern = op & m_en; exp_pulse = 1'b1;
         end
         P_ACTIVE: begin
            if (j == fire_edge + 1) rearm_edge = j + m_hold;
            if (j == rearm_edge) phase = P_REARM;
         end
         default: if (!coinc) phase = P_IDLE;
      endcase

`ifdef SIGNAL_SYNC_EN
      s       = m_pipe2;
      m_pipe2 = m_pipe1;
      m_pipe1 = SIGNAL;
`else
      s = SIGNAL;
`endif
      for (int i = 0; i < N_CH; i++)
         if (s[i] && !m_sig_prev[i]) begin
            last_rise[i] = j;
            win_at[i]    = m_win;
         end
      m_sig_prev = s;
      m_en  = CH_ENABLE;
      m_win = int'(WINDOW);
      m_maj = int'(MAJORITY);
      m_hold = int'(HOLDOFF);
      edge_n = j;
   endtask

   task automatic step();
      @(posedge CLK);
      if (!RESET) model_reset();
      else model_edge();
      #1;
      check("trigger_out", TRIGGER_OUT, exp_pulse);
      check("busy", BUSY, phase != P_IDLE);
      check("pattern", TRIGGER_PATTERN, m_pattern);
      check("count", TRIGGER_COUNT, m_count);
      if (TRIGGER_OUT === 1'b1) n_pulse++;
      if (BUSY === 1'b1) n_busy++;
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic pulse(input logic [N_CH-1:0] mask);
      SIGNAL = mask;
      step();
      SIGNAL = '0;
   endtask

   task automatic wait_pulse(input string tag);
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 12 && !seen; k++) begin
         step();
         if (TRIGGER_OUT === 1'b1) seen = 1'b1;
      end
      check(tag, seen, 1'b1);
   endtask

   int base;

   initial begin
      model_reset();
      #1;
      check("reset_trig", TRIGGER_OUT, 1'b0);
      check("reset_busy", BUSY, 1'b0);
      check("reset_count", TRIGGER_COUNT, 0);

      // Test 1: 2-of-4, ch0 then ch2 three cycles later inside a 5-cycle window
      CH_ENABLE = 4'b1111; WINDOW = 8'd5; MAJORITY = 3'd2; HOLDOFF = 8'd3;
      run(2);
      RESET = 1'b1;
      run(3);
      n_pulse = 0; n_busy = 0;
      pulse(4'b0001);
      run(2);
      pulse(4'b0100);
      run(14);
      check("t1_pulses", n_pulse, 1);
      check("t1_pattern", TRIGGER_PATTERN, 4'b0101);
      check("t1_count", TRIGGER_COUNT, 1);
      check("t1_busy_cycles", n_busy, 5);

      // Test 2: second rise after the first window expired
      COUNT_CLR = 1'b1; step(); COUNT_CLR = 1'b0;
      n_pulse = 0;
      pulse(4'b0001);
      run(5);
      pulse(4'b0010);
      run(10);
      check("t2_pulses", n_pulse, 0);
      check("t2_count", TRIGGER_COUNT, 0);

      // Test 3: 3-of-3 enabled, masked ch3 does not count
      MAJORITY = 3'd3; CH_ENABLE = 4'b0111;
      run(2);
      n_pulse = 0;
      pulse(4'b1011);
      run(1);
      check("t3_masked", n_pulse, 0);
      pulse(4'b0100);
      wait_pulse("t3_fire");
      check("t3_pattern", TRIGGER_PATTERN, 4'b0111);
      run(10);

      // Test 4: read_mode inhibit, released late then early
      MAJORITY = 3'd2; CH_ENABLE = 4'b1111;
      read_mode = 1'b1;
      run(2);
      n_pulse = 0;
      pulse(4'b0011);
      run(8);
      read_mode = 1'b0;
      run(5);
      check("t4_inhibit", n_pulse, 0);
      read_mode = 1'b1;
      pulse(4'b0011);
      step();
      read_mode = 1'b0;
      wait_pulse("t4_release_fire");
      run(10);

      // Test 5: saturation and clear-beats-fire
      COUNT_CLR = 1'b1; step(); COUNT_CLR = 1'b0;
      for (int t = 0; t < 20; t++) begin
         pulse(4'b0011);
         run(8);
      end
      check("t5_saturate", TRIGGER_COUNT, CMAX);
      pulse(4'b1100);
      wait_pulse("t5_fire");
      COUNT_CLR = 1'b1; step(); COUNT_CLR = 1'b0;
      check("t5_clr_wins", TRIGGER_COUNT, 0);
      run(10);

      // Test 6: reset in the middle of holdoff
      HOLDOFF = 8'd10;
      run(2);
      pulse(4'b0101);
      wait_pulse("t6_fire");
      run(3);
      RESET = 1'b0;
      #1;
      check("t6_async_trig", TRIGGER_OUT, 1'b0);
      check("t6_async_busy", BUSY, 1'b0);
      check("t6_async_pattern", TRIGGER_PATTERN, 0);
      check("t6_async_count", TRIGGER_COUNT, 0);
      model_reset();
      SIGNAL = 4'b0011;
      run(2);
      SIGNAL = '0;
      RESET = 1'b1;
      n_pulse = 0;
      run(15);
      check("t6_no_pulse", n_pulse, 0);

      // Randomised traffic against the model
      for (int c = 0; c < 600; c++) begin
         if ((c % 60) == 0) begin
            WINDOW    = WIN_W'($urandom_range(0, 8));
            MAJORITY  = MAJ_W'($urandom_range(0, 5));
            HOLDOFF   = HOLDOFF_W'($urandom_range(0, 4));
            CH_ENABLE = N_CH'($urandom);
         end
         SIGNAL    = N_CH'($urandom & $urandom);
         read_mode = ($urandom_range(0, 7) == 0);
         COUNT_CLR = ($urandom_range(0, 40) == 0);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
